irq_capture_unit: RTL and testbench

Upstream stage of the non-vectored interrupt path: samples the raw peripheral interrupt lines, applies per-line polarity and edge/level mode, latches pending edges, and drives the registered `IRQStatus` vector consumed by `nvIRQUnit`. Edge-mode pending bits are cleared by a write-1-to-clear pulse from the register block. A per-line overrun flag records lost edges.

---
 rtl/irq_capture_unit_pkg.sv | 13 +
 rtl/irq_capture_unit_sync2.sv | 24 ++
 rtl/irq_capture_unit.sv | 75 +++++++
 tb/tb_irq_capture_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_capture_unit_pkg.sv
// Shared interrupt-path definitions used by the capture stage and its helpers.
// Line-count default plus the mode and polarity encodings.
package irq_defs;

   localparam int IRQ_W = 32;

   localparam logic IRQ_MODE_LEVEL = 1'b0;
   localparam logic IRQ_MODE_EDGE  = 1'b1;

   localparam logic IRQ_POL_HIGH = 1'b0;
   localparam logic IRQ_POL_LOW  = 1'b1;

endpackage

// File: rtl/irq_capture_unit_sync2.sv
// Vectored two-flop synchronizer for asynchronous interrupt lines.
// Each bit is synchronized independently; no cross-bit coherence is implied.
module irq_sync2 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/irq_capture_unit.sv
// Interrupt capture stage: polarity, edge/level mode, pending and overrun flags.
// Define IRQ_CAPTURE_SYNC_EN to put a two-flop synchronizer on irqLines.
module irq_capture_unit #(
   parameter int IRQ_W = irq_defs::IRQ_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IRQ_W-1:0] irqLines,
   input  logic [IRQ_W-1:0] reg_top_inner_irqEnable,
   input  logic [IRQ_W-1:0] reg_top_inner_irqMode,
   input  logic [IRQ_W-1:0] reg_top_inner_irqPol,
   input  logic [IRQ_W-1:0] reg_top_inner_irqClear,
   output logic [IRQ_W-1:0] IRQStatus,
   output logic [IRQ_W-1:0] IRQOverrun,
   output logic [IRQ_W-1:0] IRQRaw
);

   import irq_defs::*;

   logic [IRQ_W-1:0] sampled;
   logic [IRQ_W-1:0] active;
   logic [IRQ_W-1:0] activePrev;
   logic [IRQ_W-1:0] edgeEvt;
   logic [IRQ_W-1:0] statusNext;
   logic [IRQ_W-1:0] overrunNext;

`ifdef IRQ_CAPTURE_SYNC_EN
   irq_sync2 #(
      .W(IRQ_W)
   ) uSync (
      .clk (clk),
      .rst (rst),
      .d   (irqLines),
      .q   (sampled)
   );
`else
   assign sampled = irqLines;
`endif

   assign active  = sampled ^ reg_top_inner_irqPol;
   assign edgeEvt = active & ~activePrev & reg_top_inner_irqEnable;

   // Readback is the registered copy so no input reaches an output combinationally.
   assign IRQRaw = activePrev;

   always_comb begin
      statusNext  = IRQStatus;
      overrunNext = IRQOverrun;
      for (int i = 0; i < IRQ_W; i++) begin
         if (reg_top_inner_irqMode[i] == IRQ_MODE_EDGE) begin
            statusNext[i] = edgeEvt[i]
                          | (IRQStatus[i] & ~reg_top_inner_irqClear[i]);
            overrunNext[i] = (edgeEvt[i] & IRQStatus[i]
                              & ~reg_top_inner_irqClear[i])
                           | (IRQOverrun[i] & ~reg_top_inner_irqClear[i]);
         end else begin
            statusNext[i]  = active[i] & reg_top_inner_irqEnable[i];
            overrunNext[i] = IRQOverrun[i] & ~reg_top_inner_irqClear[i];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         activePrev <= '0;
         IRQStatus  <= '0;
         IRQOverrun <= '0;
      end else begin
         activePrev <= active;
         IRQStatus  <= statusNext;
         IRQOverrun <= overrunNext;
      end
   end

endmodule

// File: tb/tb_irq_capture_unit.sv
// Randomized and directed checks of irq_capture_unit against a rule-level model.
// Latency expectations follow IRQ_CAPTURE_SYNC_EN when it is defined.
module tb_irq_capture_unit;

`ifdef IRQ_CAPTURE_SYNC_EN
   localparam int LAT = 3;
   localparam bit SYNC = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit SYNC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] lines = '0;
   logic [31:0] en = '0;
   logic [31:0] mode = '0;
   logic [31:0] pol = '0;
   logic [31:0] clr = '0;
   logic [31:0] st;
   logic [31:0] ov;
   logic [31:0] raw;

   int total = 0;
   int bad = 0;

   logic [31:0] mSt = '0;
   logic [31:0] mOv = '0;
   logic [31:0] mRaw = '0;
   logic [31:0] mPrev = '0;
   logic [31:0] h1 = '0;
   logic [31:0] h2 = '0;

   always #5 clk = ~clk;

   irq_capture_unit #(
      .IRQ_W(32)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .irqLines                (lines),
      .reg_top_inner_irqEnable (en),
      .reg_top_inner_irqMode   (mode),
      .reg_top_inner_irqPol    (pol),
      .reg_top_inner_irqClear  (clr),
      .IRQStatus               (st),
      .IRQOverrun              (ov),
      .IRQRaw                  (raw)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: s is the line vector as seen by the stage at this edge.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mSt = '0; mOv = '0; mRaw = '0; mPrev = '0; h1 = '0; h2 = '0;
         end else begin
            logic [31:0] s;
            s = SYNC ? h2 : lines;
            h2 = h1;
            h1 = lines;
            for (int i = 0; i < 32; i++) begin
               bit act, ev;
               act = s[i] ^ pol[i];
               ev = act && !mPrev[i] && en[i];
               if (mode[i]) begin
                  if (ev) begin
                     if (mSt[i] && !clr[i]) mOv[i] = 1'b1;
                     else if (clr[i]) mOv[i] = 1'b0;
                     mSt[i] = 1'b1;
                  end else if (clr[i]) begin
                     mSt[i] = 1'b0;
                     mOv[i] = 1'b0;
                  end
               end else begin
                  mSt[i] = act && en[i];
                  if (clr[i]) mOv[i] = 1'b0;
               end
               mPrev[i] = act;
            end
            mRaw = mPrev;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("model_status", st, mSt);
         check("model_overrun", ov, mOv);
         check("model_raw", raw, mRaw);
      end
   end

   task automatic doReset();
      rst = 1'b1;
      lines = '0; clr = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      en = 32'hFFFF_FFFF;
      mode = 32'hFFFF_FFFF;
      pol = '0;
      @(negedge clk);
      check("reset_status", st, 32'h0);
      check("reset_overrun", ov, 32'h0);
      check("reset_raw", raw, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // single edge on line 3
      lines = 32'h8;
      @(negedge clk);
      lines = '0;
      repeat (LAT - 1) @(negedge clk);
      check("edge3_set", st, 32'h8);
      repeat (3) @(negedge clk);
      check("edge3_hold", st, 32'h8);
      clr = 32'h8;
      @(negedge clk);
      clr = '0;
      check("edge3_clear", st, 32'h0);

      // overrun on line 5
      lines = 32'h20;
      @(negedge clk);
      lines = '0;
      repeat (LAT + 1) @(negedge clk);
      check("ovr_first", st, 32'h20);
      lines = 32'h20;
      @(negedge clk);
      lines = '0;
      repeat (LAT - 1) @(negedge clk);
      check("ovr_flag", ov, 32'h20);
      repeat (2) @(negedge clk);
      for (int c = 0; c < LAT; c++) begin
         lines = (c == 0) ? 32'h20 : 32'h0;
         clr = (c == LAT - 1) ? 32'h20 : 32'h0;
         @(negedge clk);
      end
      lines = '0;
      clr = '0;
      check("ovr_setwins_st", st, 32'h20);
      check("ovr_setwins_ov", ov, 32'h0);
      clr = 32'h20;
      @(negedge clk);
      clr = '0;
      check("ovr_cleared", st, 32'h0);

      // level mode, active-low, line 0
      mode = 32'hFFFF_FFFE;
      pol = 32'h1;
      repeat (LAT) @(negedge clk);
      check("lvl_low_active", st, 32'h1);
      clr = 32'h1;
      @(negedge clk);
      clr = '0;
      @(negedge clk);
      check("lvl_clear_ignored", st, 32'h1);
      lines = 32'h1;
      repeat (LAT) @(negedge clk);
      check("lvl_release", st, 32'h0);

      // enable mask
      doReset();
      mode = 32'hFFFF_FFFF;
      pol = '0;
      en = 32'h0A00_0000;
      @(negedge clk);
      lines = 32'hFFFF_FFFF;
      @(negedge clk);
      lines = '0;
      repeat (LAT - 1) @(negedge clk);
      check("mask_set", st, 32'h0A00_0000);
      en = '0;
      repeat (4) @(negedge clk);
      check("mask_hold", st, 32'h0A00_0000);
      clr = 32'h0A00_0000;
      @(negedge clk);
      clr = '0;
      check("mask_clear", st, 32'h0);

      // asynchronous reset mid-operation
      en = 32'hFFFF_FFFF;
      mode = '0;
      lines = 32'h0000_00FF;
      repeat (LAT + 1) @(negedge clk);
      check("pre_rst_status", st, 32'h0000_00FF);
      #2 rst = 1'b1;
      #1;
      check("async_rst_status", st, 32'h0);
      check("async_rst_overrun", ov, 32'h0);
      check("async_rst_raw", raw, 32'h0);
      @(negedge clk);
      lines = '0;
      @(negedge clk);
      rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (n % 64 == 0) begin
            en = $urandom;
            mode = $urandom;
            pol = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
         end
         lines = $urandom & $urandom;
         clr = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
         @(negedge clk);
      end
      clr = '0;
      lines = '0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
